// File: rtl/pwm_led_pkg.sv
// Shared constants, CTRL register layout and gamma helper for the LED PWM array.
package pwm_led_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned PWM_W         = 8;
    localparam int unsigned PROD_W        = 2 * PWM_W;
    localparam int unsigned PWM_MAX       = (2 ** PWM_W) - 1;
    localparam int unsigned STEP_W        = 4;

    // All-ones pattern; the top truncates it to its own address width.
    localparam logic [31:0] CTRL_ADDR     = '1;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_STEP_LSB = 4;
    localparam int unsigned CTRL_STEP_MSB = 7;

    // Square-law brightness correction: level^2 / (2^W-1), truncated.
    function automatic logic [PWM_W-1:0] gamma(input logic [PWM_W-1:0] level);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(level) * PROD_W'(level);
        return PWM_W'(prod / PROD_W'(PWM_MAX));
    endfunction

endpackage

// File: rtl/pwm_led_if.sv
// Device bus bundle: address/strobe/direction/data towards the LED block.
interface pwm_led_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    import pwm_led_pkg::*;

    logic [ADDR_WIDTH-1:0] address;
    logic                  enable;
    logic                  mode;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W-1:0]     data_out;

    modport master (output address, enable, mode, data_in, input data_out);
    modport slave  (input address, enable, mode, data_in, output data_out);

endinterface

// File: rtl/pwm_led_channel.sv
// One LED channel: fade level, gamma, period-aligned duty latch and compare.
module pwm_led_channel
    import pwm_led_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [PWM_W-1:0]  target,
    input  logic [STEP_W-1:0] step,
    input  logic              tick,
    input  logic [PWM_W-1:0]  cnt,
    input  logic              period_end,
    input  logic              out_en,
    output logic              led
);

    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] step_w;
    logic [PWM_W-1:0] level_nxt_c;
    logic [PWM_W-1:0] duty_nxt_c;
    logic [PWM_W-1:0] cnt_nxt_c;

    // Fade toward target by step per tick, saturating; step 0 tracks target directly.
    always_comb begin
        level_nxt_c = level;
        step_w      = PWM_W'(step);
        if (step == '0) begin
            level_nxt_c = target;
        end else if (tick) begin
            if (target > level) begin
                level_nxt_c = ((target - level) > step_w) ? (level + step_w) : target;
            end else if (target < level) begin
                level_nxt_c = ((level - target) > step_w) ? (level - step_w) : target;
            end
        end
    end

    // Duty and counter as they will be after this edge, so LED lines up with the period.
    always_comb begin
        duty_nxt_c = period_end ? gamma(level) : duty;
        cnt_nxt_c  = period_end ? '0 : (cnt + PWM_W'(1));
    end

    // Level, duty latch and registered PWM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
            duty  <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_nxt_c;
            duty  <= duty_nxt_c;
            led   <= out_en && (cnt_nxt_c < duty_nxt_c);
        end
    end

endmodule

// File: rtl/pwm_led_array.sv
// N-channel gamma-corrected LED PWM driver with hardware fade on the 8-bit device bus.
module pwm_led_array
    import pwm_led_pkg::*;
#(
    parameter int unsigned CHANNELS   = 10,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned PWM_WIDTH  = 8,
    parameter int unsigned FADE_DIV   = 65536
) (
    input  logic                clk,
    input  logic                reset,
    pwm_led_if.slave            bus,
    output logic [CHANNELS-1:0] LED
);

    localparam int unsigned PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'((2 ** PWM_WIDTH) - 2);
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [PWM_W-1:0]     target [CHANNELS];
    logic                 en_q;
    logic [STEP_W-1:0]    step_q;
    logic [PWM_WIDTH-1:0] cnt;
    logic [PRE_W-1:0]     prescaler;

    logic                 wr_c;
    logic                 rd_c;
    logic                 ctrl_sel_c;
    logic                 en_nxt_c;
    logic                 tick_c;
    logic                 period_end_c;
    logic [DATA_W-1:0]    rdata_c;

    // Bus decode, read mux and the enable value that will hold after this edge.
    always_comb begin
        wr_c       = bus.enable && bus.mode;
        rd_c       = bus.enable && !bus.mode;
        ctrl_sel_c = (bus.address == ADDR_WIDTH'(CTRL_ADDR));
        en_nxt_c   = (wr_c && ctrl_sel_c) ? bus.data_in[CTRL_EN_BIT] : en_q;
        rdata_c    = '0;
        if (ctrl_sel_c) begin
            rdata_c[CTRL_STEP_MSB:CTRL_STEP_LSB] = step_q;
            rdata_c[CTRL_EN_BIT]                 = en_q;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.address == ADDR_WIDTH'(i)) begin
                rdata_c = target[i];
            end
        end
    end

    // Period and fade-tick strobes.
    always_comb begin
        tick_c       = (prescaler == PRE_LAST);
        period_end_c = (cnt == CNT_LAST);
    end

    // TARGET/CTRL register writes and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
            end
            en_q         <= 1'b1;
            step_q       <= '0;
            bus.data_out <= '0;
        end else begin
            if (wr_c) begin
                if (ctrl_sel_c) begin
                    en_q   <= bus.data_in[CTRL_EN_BIT];
                    step_q <= bus.data_in[CTRL_STEP_MSB:CTRL_STEP_LSB];
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (bus.address == ADDR_WIDTH'(i)) begin
                        target[i] <= bus.data_in;
                    end
                end
            end
            if (rd_c) begin
                bus.data_out <= rdata_c;
            end
        end
    end

    // PWM period counter (0..2^W-2) and fade prescaler (0..FADE_DIV-1).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            prescaler <= '0;
        end else begin
            cnt       <= period_end_c ? '0 : (cnt + PWM_WIDTH'(1));
            prescaler <= tick_c ? '0 : (prescaler + PRE_W'(1));
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_led_channel u_ch (
            .clk        (clk),
            .reset      (reset),
            .target     (target[i]),
            .step       (step_q),
            .tick       (tick_c),
            .cnt        (cnt),
            .period_end (period_end_c),
            .out_en     (en_nxt_c),
            .led        (LED[i])
        );
    end

endmodule
